// File: rtl/matcher_lookup_arb_pkg.sv
// matcher_lookup_arb shared types: FSM state encoding, counter width,
// default bus widths and small index/saturation helpers.
package matcher_lookup_arb_pkg;

  localparam int OF_HEADER_REG_WIDTH  = 64;
  localparam int OF_ACTION_DATA_WIDTH = 32;
  localparam int OF_ACTION_CTRL_WIDTH = 16;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/matcher_lookup_arb_rr_grant_arb.sv
// rr_grant_arb: combinational round-robin picker.
// Ports: req (request vector), ptr (start index) -> grant (one-hot), idx, any.
module rr_grant_arb
  import matcher_lookup_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  // Scan from the far end back toward ptr so the closest
  // set bit at or after ptr is the last one written.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = '0;
    any   = |req;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        idx   = j;
        grant = '0;
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matcher_lookup_arb.sv
// matcher_lookup_arb: round-robin share of one matcher among NUM_REQ
// header parsers, with lookup timeout and lookup/hit/timeout counters.
// Ports: clk, reset_n; req_valid/req_header in, req_ack + rsp_* out;
// mt_* matcher handshake; lookup_cnt/hit_cnt/timeout_cnt statistics.
module matcher_lookup_arb
  import matcher_lookup_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int HDR_WIDTH      = OF_HEADER_REG_WIDTH,
  parameter int ADATA_WIDTH    = OF_ACTION_DATA_WIDTH,
  parameter int ACTRL_WIDTH    = OF_ACTION_CTRL_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*HDR_WIDTH-1:0] req_header,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic                         rsp_hit,
  output logic                         rsp_timeout,
  output logic [ADATA_WIDTH-1:0]       rsp_data,
  output logic [ACTRL_WIDTH-1:0]       rsp_ctrl,
  output logic [HDR_WIDTH-1:0]         mt_header_bus,
  output logic                         mt_headers_valid,
  input  logic                         mt_action_valid,
  input  logic                         mt_action_hit,
  input  logic [ADATA_WIDTH-1:0]       mt_action_data,
  input  logic [ACTRL_WIDTH-1:0]       mt_action_ctrl,
  output logic [CNT_W-1:0]             lookup_cnt,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [CNT_W-1:0]             timeout_cnt
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        g_idx;
  logic [NUM_REQ-1:0]   g_oh;
  logic [TW-1:0]        timer;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [HDR_WIDTH-1:0] hdr_sel;

  rr_grant_arb #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    hdr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        hdr_sel = req_header[i*HDR_WIDTH +: HDR_WIDTH];
      end
    end
  end

  // Ack, response and counters are all loaded on the edge that
  // enters RESP, so they are visible together during RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      g_idx            <= '0;
      g_oh             <= '0;
      timer            <= '0;
      req_ack          <= '0;
      rsp_hit          <= 1'b0;
      rsp_timeout      <= 1'b0;
      rsp_data         <= '0;
      rsp_ctrl         <= '0;
      mt_header_bus    <= '0;
      mt_headers_valid <= 1'b0;
      lookup_cnt       <= '0;
      hit_cnt          <= '0;
      timeout_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            g_oh          <= arb_grant;
            g_idx         <= arb_idx;
            mt_header_bus <= hdr_sel;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mt_headers_valid <= 1'b1;
          timer            <= '0;
          state            <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (mt_action_valid) begin
            req_ack          <= g_oh;
            rsp_hit          <= mt_action_hit;
            rsp_timeout      <= 1'b0;
            rsp_data         <= mt_action_hit ? mt_action_data : '0;
            rsp_ctrl         <= mt_action_hit ? mt_action_ctrl : '0;
            mt_headers_valid <= 1'b0;
            lookup_cnt       <= sat_inc(lookup_cnt);
            if (mt_action_hit) begin
              hit_cnt <= sat_inc(hit_cnt);
            end
            state <= S_RESP;
          end else if (timer == TLAST) begin
            req_ack          <= g_oh;
            rsp_hit          <= 1'b0;
            rsp_timeout      <= 1'b1;
            rsp_data         <= '0;
            rsp_ctrl         <= '0;
            mt_headers_valid <= 1'b0;
            lookup_cnt       <= sat_inc(lookup_cnt);
            timeout_cnt      <= sat_inc(timeout_cnt);
            state            <= S_RESP;
          end
        end
        S_RESP: begin
          req_ack <= '0;
          rr_ptr  <= (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + 1'b1;
          state   <= S_GAP;
        end
        S_GAP: begin
          // Extra low cycle lets the matcher's edge detector re-arm.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matcher_lookup_arb.sv
// tb_matcher_lookup_arb: randomized requesters and matcher model,
// checked against a transaction-level reference of the arbiter.
module tb_matcher_lookup_arb;

  localparam int NR = 4;
  localparam int HW = 64;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int T  = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NR-1:0]    req_valid;
  logic [NR*HW-1:0] req_header;
  logic [NR-1:0]    req_ack;
  logic             rsp_hit;
  logic             rsp_timeout;
  logic [AW-1:0]    rsp_data;
  logic [CW-1:0]    rsp_ctrl;
  logic [HW-1:0]    mt_header_bus;
  logic             mt_headers_valid;
  logic             mav;
  logic             mah;
  logic [AW-1:0]    mad;
  logic [CW-1:0]    mac;
  logic [31:0]      lookup_cnt;
  logic [31:0]      hit_cnt;
  logic [31:0]      timeout_cnt;

  always #5 clk = ~clk;

  matcher_lookup_arb #(
    .NUM_REQ        (NR),
    .HDR_WIDTH      (HW),
    .ADATA_WIDTH    (AW),
    .ACTRL_WIDTH    (CW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_header       (req_header),
    .req_ack          (req_ack),
    .rsp_hit          (rsp_hit),
    .rsp_timeout      (rsp_timeout),
    .rsp_data         (rsp_data),
    .rsp_ctrl         (rsp_ctrl),
    .mt_header_bus    (mt_header_bus),
    .mt_headers_valid (mt_headers_valid),
    .mt_action_valid  (mav),
    .mt_action_hit    (mah),
    .mt_action_data   (mad),
    .mt_action_ctrl   (mac),
    .lookup_cnt       (lookup_cnt),
    .hit_cnt          (hit_cnt),
    .timeout_cnt      (timeout_cnt)
  );

  logic [NR-1:0] rv;
  logic [HW-1:0] hdr [NR];

  assign req_valid = rv;

  always_comb begin
    req_header = '0;
    for (int i = 0; i < NR; i++) req_header[i*HW +: HW] = hdr[i];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference state
  int            ptr;
  logic [31:0]   m_lk, m_hit, m_to;
  bit            busy, pend;
  int            g, cyc, resp_k, acks;
  bit            r_hit;
  logic [AW-1:0] r_data;
  logic [CW-1:0] r_ctrl;
  logic [HW-1:0] cur_hdr;
  logic [NR-1:0] h0, h1;
  int            low_run;
  int            grants[$];
  // knobs
  int raise_pct, lat_lo, lat_hi, hit_pct, never_pct;
  bit fix_en;

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int s = 0; s < NR; s++) if (v[(p + s) % NR]) return (p + s) % NR;
    return -1;
  endfunction

  task automatic raise(input int i, input logic [HW-1:0] h);
    rv[i] = 1'b1;
    hdr[i] = h;
    h0 = rv;
  endtask

  task automatic step();
    logic [NR-1:0] acked;
    int ack_k;
    bit cap, eh;
    @(negedge clk);
    acked = '0;
    if (busy || pend) cyc++;
    if (busy) begin
      cap = (resp_k <= T);
      ack_k = cap ? resp_k + 1 : T + 1;
      if (cyc == ack_k) begin
        eh = cap && r_hit;
        m_lk = sat(m_lk);
        if (eh) m_hit = sat(m_hit);
        if (!cap) m_to = sat(m_to);
        chk("ack", req_ack, 64'(1) << g);
        chk("rsp_hit", rsp_hit, eh);
        chk("rsp_timeout", rsp_timeout, !cap);
        chk("rsp_data", rsp_data, eh ? r_data : '0);
        chk("rsp_ctrl", rsp_ctrl, eh ? r_ctrl : '0);
        chk("hv_resp", mt_headers_valid, 0);
        chk("lookup_cnt", lookup_cnt, m_lk);
        chk("hit_cnt", hit_cnt, m_hit);
        chk("timeout_cnt", timeout_cnt, m_to);
        rv[g] = 1'b0;
        acked[g] = 1'b1;
        ptr = (g + 1) % NR;
        busy = 1'b0;
        acks++;
        grants.push_back(g);
      end else begin
        chk("ack_wait", req_ack, 0);
        chk("hv_hold", mt_headers_valid, 1);
        chk("hdr_hold", mt_header_bus, cur_hdr);
      end
    end else begin
      chk("ack_idle", req_ack, 0);
      if (mt_headers_valid) begin
        chk("hv_gap", low_run >= 2, 1);
        g = rr_pick(h1, ptr);
        chk("grant_valid", g >= 0, 1);
        if (g < 0) g = 0;
        cur_hdr = hdr[g];
        chk("grant_hdr", mt_header_bus, cur_hdr);
        busy = 1'b1;
        pend = 1'b1;
        cyc = 1;
        if (fix_en) begin
          resp_k = 3;
          r_hit = 1'b1;
          r_data = 32'h1234;
          r_ctrl = 16'h00AB;
        end else begin
          if ($urandom_range(99) < never_pct)
            resp_k = T + 1 + $urandom_range(2);
          else
            resp_k = $urandom_range(lat_hi, lat_lo);
          r_hit = ($urandom_range(99) < hit_pct);
          r_data = $urandom;
          r_ctrl = 16'($urandom);
        end
      end
    end
    // matcher: garbage on the data buses whenever valid is low
    mav = 1'b0;
    mah = 1'($urandom);
    mad = $urandom;
    mac = 16'($urandom);
    if (pend && cyc == resp_k) begin
      mav = 1'b1;
      mah = r_hit;
      mad = r_data;
      mac = r_ctrl;
      pend = 1'b0;
    end
    if (pend && cyc > T + 3) pend = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (!rv[i] && !acked[i] && $urandom_range(99) < raise_pct) begin
        rv[i] = 1'b1;
        hdr[i] = {$urandom, $urandom};
      end
    end
    h1 = h0;
    h0 = rv;
    low_run = mt_headers_valid ? 0 : low_run + 1;
  endtask

  task automatic apply_reset(input bit keep);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ack", req_ack, 0);
    chk("rst_hv", mt_headers_valid, 0);
    chk("rst_hdr", mt_header_bus, 0);
    chk("rst_hit", rsp_hit, 0);
    chk("rst_to", rsp_timeout, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_ctrl", rsp_ctrl, 0);
    chk("rst_lk", lookup_cnt, 0);
    chk("rst_hc", hit_cnt, 0);
    chk("rst_tc", timeout_cnt, 0);
    busy = 1'b0;
    pend = 1'b0;
    ptr = 0;
    m_lk = '0;
    m_hit = '0;
    m_to = '0;
    mav = 1'b0;
    low_run = 100;
    if (!keep) rv = '0;
    else begin
      for (int i = 0; i < NR; i++) begin
        if (!rv[i]) begin
          rv[i] = 1'b1;
          hdr[i] = {$urandom, $urandom};
        end
      end
    end
    h0 = rv;
    h1 = rv;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_acks(input int n, input int budget);
    int tgt;
    tgt = acks + n;
    for (int c = 0; c < budget && acks < tgt; c++) step();
    chk("ack_budget", acks, tgt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hb;
    int base;
    rv = '0;
    for (int i = 0; i < NR; i++) hdr[i] = '0;
    mav = 1'b0; mah = 1'b0; mad = '0; mac = '0;
    acks = 0; cyc = 0; resp_k = 0; g = 0;
    raise_pct = 0; lat_lo = 1; lat_hi = 6;
    hit_pct = 50; never_pct = 0; fix_en = 1'b0;
    repeat (2) @(negedge clk);
    apply_reset(1'b0);

    // single request, hit after 3 cycles
    fix_en = 1'b1;
    raise(0, 64'hA5A5_A5A5_A5A5_A5A5);
    run_acks(1, 40);
    chk("t1_ack", req_ack, 4'b0001);
    chk("t1_hit", rsp_hit, 1);
    chk("t1_data", rsp_data, 32'h1234);
    chk("t1_lk", lookup_cnt, 1);
    chk("t1_hc", hit_cnt, 1);
    fix_en = 1'b0;

    // all four held: strict rotation from req0
    apply_reset(1'b0);
    for (int i = 0; i < NR; i++) raise(i, {$urandom, $urandom});
    raise_pct = 100;
    base = grants.size();
    run_acks(5, 200);
    for (int j = 0; j < 5; j++)
      if (base + j < grants.size()) chk("t2_order", grants[base+j], j % NR);
    raise_pct = 0;
    run_acks(3, 200);

    // matcher silent, late stray valid
    never_pct = 100;
    raise(2, {$urandom, $urandom});
    run_acks(1, 80);
    chk("t3_timeout", rsp_timeout, 1);
    chk("t3_data", rsp_data, 0);
    chk("t3_tc", timeout_cnt, 1);
    repeat (8) step();
    never_pct = 0;

    // misses with garbage data
    hit_pct = 0;
    hb = m_hit;
    raise(1, {$urandom, $urandom});
    raise(3, {$urandom, $urandom});
    raise_pct = 50;
    run_acks(3, 200);
    chk("t4_hc", hit_cnt, hb);
    raise_pct = 0;
    hit_pct = 50;

    // reset in the middle of WAIT
    never_pct = 100;
    raise_pct = 100;
    for (int c = 0; c < 200 && !(busy && cyc == 3); c++) step();
    chk("t5_reach", busy && cyc == 3, 1);
    apply_reset(1'b1);
    never_pct = 0;
    raise_pct = 0;
    run_acks(1, 60);
    chk("t5_first", grants[$], 0);
    chk("t5_lk", lookup_cnt, 1);

    // saturation of lookup counter
    force dut.lookup_cnt = 32'hFFFF_FFFE;
    #1 release dut.lookup_cnt;
    m_lk = 32'hFFFF_FFFE;
    raise_pct = 100;
    run_acks(3, 200);
    chk("t6_sat", lookup_cnt, 32'hFFFF_FFFF);

    // random mix
    raise_pct = 30;
    lat_lo = 1;
    lat_hi = T;
    hit_pct = 60;
    never_pct = 15;
    run_acks(150, 150 * 40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
